db_cycle_seq: RTL and testbench
===============================

Name: db_cycle_seq

Overview:
Sequences one Z80 external bus machine cycle (opcode fetch, memory read/write, I/O read/write) through the T-states. It drives the four control inputs of the data-pin latch block (latch from pins, latch from internal bus, drive pins, drive internal bus) and the active-low bus strobes. It sits between the CPU sequencer, which requests cycles, and the data-pin latch and pad ring.

Parameters:
IO_AUTO_WAIT, 1, when 1 an I/O cycle inserts one automatic wait state (TWA) after T2.
TIMEOUT, 255, maximum consecutive TW states before the cycle is forced to T3 (used only with the optional feature).
CNT_W, 8, width of the wait counter; TIMEOUT must fit in CNT_W bits.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new cycle; single-cycle qualifier
cyc_kind  input  2  00 opcode fetch, 01 memory, 10 I/O, 11 treated as 01
cyc_wr  input  1  1 = write; ignored for fetch
wait_n  input  1  pin WAIT, active low
busy  output  1  cycle in progress (state != IDLE)
done  output  1  high during the final T-state of a cycle
timeout  output  1  one-cycle pulse when a wait timeout forces T3 (optional feature)
bus_db_pin_re  output  1  latch captures data from the pins
ctl_bus_db_we  output  1  latch captures data from the internal bus
bus_db_pin_oe  output  1  latch drives the pins
ctl_bus_db_oe  output  1  latch drives the internal bus
m1_n, mreq_n, iorq_n, rd_n, wr_n  output  1 each  bus strobes, active low

Behaviour:
- States: IDLE, T1, T2, TWA, TW, T3, T4. All outputs are decoded from the registered state and the latched kind/wr (Moore).
- Reset, asynchronous: state=IDLE; wait counter=0; busy=0, done=0, timeout=0; all four latch controls=0; all strobes=1. A reset mid-cycle aborts the cycle with no completion pulse.
- Accepting a request: start is accepted in IDLE, or in the final state while done=1 (back-to-back with no idle gap). On acceptance, cyc_kind and cyc_wr are latched and the next state is T1. start is ignored at all other times.
- Transitions:
  - T1 -> T2.
  - T2 -> TWA if the cycle is I/O and IO_AUTO_WAIT=1.
  - Wait-sample state: T2 (or TWA for I/O with the auto wait), and TW. If wait_n=0 at the clock edge, go to TW; otherwise go to T3.
  - TWA takes precedence: wait_n is not sampled in T2 of an I/O cycle while TWA is enabled.
  - T3 -> T4 for a fetch. For other kinds, T3 is final: it goes to T1 if start is accepted, else IDLE.
  - T4 is final for a fetch: it goes to T1 if start is accepted, else IDLE.
- Strobes:
  - m1_n=0 in T1, T2, TW and T3 of a fetch.
  - mreq_n=0 in T2, TW and T3 of fetch/memory cycles.
  - iorq_n=0 in TWA, TW and T3 of an I/O cycle.
  - rd_n=0 in T2, TWA, TW and T3 of a read (a fetch is a read).
  - wr_n=0 in TWA, TW and T3 of an I/O write, and in TW and T3 of a memory write.
- Reads:
  - bus_db_pin_re=1 in T2, TWA and TW, so the latch resamples the pins on every falling edge while waiting; the last capture is the value held.
  - ctl_bus_db_oe=1 in T3, and also in T4 for a fetch.
  - ctl_bus_db_we=0 and bus_db_pin_oe=0 throughout.
- Writes:
  - ctl_bus_db_we=1 in T1 only.
  - bus_db_pin_oe=1 in T2, TWA, TW and T3.
  - bus_db_pin_re=0 and ctl_bus_db_oe=0 throughout.
  - bus_db_pin_re and ctl_bus_db_we are never 1 in the same state.
- Latency (no waits): fetch 4 cycles, memory 3 cycles, I/O 4 cycles with IO_AUTO_WAIT=1 (3 with 0). Each TW adds 1 cycle.

Optional Feature:
DB_SEQ_WAIT_TIMEOUT_EN:
- Defined:
  - The wait counter clears on entry to T1 and increments on each cycle spent in TW, saturating at all-ones.
  - If the counter equals TIMEOUT in TW, the next state is T3 regardless of wait_n, and timeout=1 for that one cycle.
  - Reset clears the counter.
- Undefined: the counter is absent, timeout is tied to 0, and wait_n can hold TW indefinitely.

Test Plan:
- Reset asserted mid-T2 of a memory read -> immediately busy=0, rd_n=mreq_n=1, bus_db_pin_re=0; state IDLE after release.
- Fetch with wait_n=1 -> states T1 T2 T3 T4; m1_n=0 for 3 cycles; bus_db_pin_re=1 in T2 only; ctl_bus_db_oe=1 for 2 cycles; done=1 in T4.
- Memory write with wait_n=0 for 2 samples -> T1 T2 TW TW T3; ctl_bus_db_we=1 in T1 only; bus_db_pin_oe=1 for 4 cycles; wr_n=0 for 3 cycles.
- I/O read, IO_AUTO_WAIT=1, wait_n=0 held while in T2 -> still goes to TWA then T3; iorq_n=0 for 2 cycles; total 4 cycles.
- start held high continuously during memory reads -> T1 follows T3 with no IDLE gap; start during T2 ignored; cyc_kind change mid-cycle has no effect.
- With DB_SEQ_WAIT_TIMEOUT_EN, TIMEOUT=3, wait_n=0 stuck -> exactly 3 TW cycles, then T3 with timeout=1 for one cycle and done=1 in that T3.

Source files
------------

// File: rtl/db_cycle_seq.sv
// db_cycle_seq: Z80 external bus machine-cycle sequencer.
// Steps one fetch / memory / I/O cycle through its T-states. It drives the
// data-pin latch controls and the active-low bus strobes. Every output is
// decoded from the registered state plus the latched kind/direction.
// Optional feature macro: DB_SEQ_WAIT_TIMEOUT_EN (adds the TW wait-timeout
// counter and the timeout pulse).
module db_cycle_seq #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cyc_kind,
  input  logic       cyc_wr,
  input  logic       wait_n,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       bus_db_pin_re,
  output logic       ctl_bus_db_we,
  output logic       bus_db_pin_oe,
  output logic       ctl_bus_db_oe,
  output logic       m1_n,
  output logic       mreq_n,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4} state_t;

  localparam logic [1:0] K_FETCH = 2'b00;
  localparam logic [1:0] K_MEM   = 2'b01;
  localparam logic [1:0] K_IO    = 2'b10;

  state_t     state, state_n;
  logic [1:0] kind_q;
  logic       wr_q;
  logic       is_fetch, is_io, is_rd;
  logic       accept;
  logic       to_hit;
  state_t     wait_go;

  assign is_fetch = (kind_q == K_FETCH);
  assign is_io    = (kind_q == K_IO);
  // A fetch is always a read; wr_q is already forced low for fetches.
  assign is_rd    = ~wr_q;

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_T4) | ((state == S_T3) & ~is_fetch);
  // New request taken in IDLE or in the final T-state (back-to-back).
  assign accept = start & ((state == S_IDLE) | done);
  // Result of a wait sample: stretch while WAIT is asserted.
  assign wait_go = wait_n ? S_T3 : S_TW;

`ifdef DB_SEQ_WAIT_TIMEOUT_EN
  logic [CNT_W-1:0] wcnt;
  logic             to_q;

  // Counts TW cycles of the current machine cycle; value k while in the k-th TW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     wcnt <= '0;
    else if (state_n == S_T1)                      wcnt <= '0;
    else if ((state_n == S_TW) && (wcnt != '1))    wcnt <= wcnt + CNT_W'(1);
  end

  assign to_hit = (state == S_TW) && (wcnt == CNT_W'(TIMEOUT));

  // Timeout flag is high during the T3 that the forced exit lands in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= 1'b0;
    else       to_q <= to_hit;
  end

  assign timeout = to_q;
`else
  logic [CNT_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = CNT_W'(TIMEOUT);
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Latch kind/direction on acceptance; 11 folds to memory, fetch never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q <= K_FETCH;
      wr_q   <= 1'b0;
    end else if (accept) begin
      kind_q <= (cyc_kind == 2'b11) ? K_MEM : cyc_kind;
      wr_q   <= cyc_wr & (cyc_kind != K_FETCH);
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = S_T1;
      S_T1:   state_n = S_T2;
      // The I/O auto wait overrides WAIT sampling in T2.
      S_T2:   state_n = (is_io && (IO_AUTO_WAIT != 0)) ? S_TWA : wait_go;
      S_TWA:  state_n = wait_go;
      S_TW:   state_n = to_hit ? S_T3 : wait_go;
      S_T3:   if (is_fetch)   state_n = S_T4;
              else            state_n = accept ? S_T1 : S_IDLE;
      S_T4:   state_n = accept ? S_T1 : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Moore decode of strobes and latch controls.
  always_comb begin
    bus_db_pin_re = 1'b0;
    ctl_bus_db_we = 1'b0;
    bus_db_pin_oe = 1'b0;
    ctl_bus_db_oe = 1'b0;
    m1_n          = 1'b1;
    mreq_n        = 1'b1;
    iorq_n        = 1'b1;
    rd_n          = 1'b1;
    wr_n          = 1'b1;
    unique case (state)
      S_T1: begin
        m1_n          = ~is_fetch;
        ctl_bus_db_we = ~is_rd;
      end
      S_T2: begin
        m1_n          = ~is_fetch;
        mreq_n        = is_io;
        rd_n          = ~is_rd;
        bus_db_pin_re = is_rd;
        bus_db_pin_oe = ~is_rd;
      end
      S_TWA: begin
        iorq_n        = ~is_io;
        rd_n          = ~is_rd;
        wr_n          = is_rd;
        bus_db_pin_re = is_rd;
        bus_db_pin_oe = ~is_rd;
      end
      S_TW: begin
        m1_n          = ~is_fetch;
        mreq_n        = is_io;
        iorq_n        = ~is_io;
        rd_n          = ~is_rd;
        wr_n          = is_rd;
        bus_db_pin_re = is_rd;
        bus_db_pin_oe = ~is_rd;
      end
      S_T3: begin
        m1_n          = ~is_fetch;
        mreq_n        = is_io;
        iorq_n        = ~is_io;
        rd_n          = ~is_rd;
        wr_n          = is_rd;
        ctl_bus_db_oe = is_rd;
        bus_db_pin_oe = ~is_rd;
      end
      S_T4: ctl_bus_db_oe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_db_cycle_seq.sv
// Bench for db_cycle_seq: directed tables, a mid-cycle reset, and random
// transactions checked cycle-by-cycle against a phase-list reference model.
module tb_db_cycle_seq;
  localparam int TO = 3;
  localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TWA = 3, P_TW = 4, P_T3 = 5, P_T4 = 6;

  logic       clk = 1'b0;
  logic       reset, start, cyc_wr, wait_n;
  logic [1:0] cyc_kind;
  logic       busy, done, timeout, bus_db_pin_re, ctl_bus_db_we, bus_db_pin_oe, ctl_bus_db_oe;
  logic       m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [11:0] obs;

  db_cycle_seq #(.IO_AUTO_WAIT(1), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cyc_kind(cyc_kind), .cyc_wr(cyc_wr),
    .wait_n(wait_n), .busy(busy), .done(done), .timeout(timeout),
    .bus_db_pin_re(bus_db_pin_re), .ctl_bus_db_we(ctl_bus_db_we),
    .bus_db_pin_oe(bus_db_pin_oe), .ctl_bus_db_oe(ctl_bus_db_oe),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, timeout, bus_db_pin_re, ctl_bus_db_we, bus_db_pin_oe,
                ctl_bus_db_oe, m1_n, mreq_n, iorq_n, rd_n, wr_n};

  typedef struct {
    bit       start;
    bit [1:0] kind;
    bit       wr;
    bit       wait_n;
    bit [11:0] exp;
  } vec_t;

  vec_t tl[$];
  int checks = 0, errors = 0;
  int n_m1, n_mreq, n_iorq, n_rd, n_wr, n_re, n_we, n_poe, n_coe, n_busy, n_done, n_to;

  // Expected outputs for one phase, straight from the bus-cycle rules.
  function automatic bit [11:0] model(int ph, int k, bit wr, bit to);
    bit rd, m1, mreq, iorq, rdl, wrl, re, we, poe, coe, fin;
    rd   = (k == 0) || !wr;
    m1   = (k == 0) && (ph == P_T1 || ph == P_T2 || ph == P_TW || ph == P_T3);
    mreq = (k != 2) && (ph == P_T2 || ph == P_TW || ph == P_T3);
    iorq = (k == 2) && (ph == P_TWA || ph == P_TW || ph == P_T3);
    rdl  = rd && (ph == P_T2 || ph == P_TWA || ph == P_TW || ph == P_T3);
    wrl  = !rd && (ph == P_TW || ph == P_T3 || (k == 2 && ph == P_TWA));
    re   = rd && (ph == P_T2 || ph == P_TWA || ph == P_TW);
    coe  = rd && (ph == P_T3 || (k == 0 && ph == P_T4));
    we   = !rd && ph == P_T1;
    poe  = !rd && (ph == P_T2 || ph == P_TWA || ph == P_TW || ph == P_T3);
    fin  = (ph == P_T4) || (ph == P_T3 && k != 0);
    return {ph != P_IDLE, fin, to, re, we, poe, coe, !m1, !mreq, !iorq, !rdl, !wrl};
  endfunction

  task automatic check(string name, bit [11:0] act, bit [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_idle(int n);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      e.start = 1'b0; e.kind = 2'($urandom); e.wr = 1'($urandom); e.wait_n = 1'($urandom);
      e.exp = model(P_IDLE, 0, 1'b0, 1'b0);
      tl.push_back(e);
    end
  endtask

  // Append one machine cycle; the start request goes on the previous entry.
  task automatic add_txn(int kin, bit wr, int nw, bit hold, bit stuck);
    vec_t e;
    int k, s, nwe;
    int ph[$];
    bit to_hit, wre;
    to_hit = 1'b0;
    nwe = nw;
    k = (kin == 3) ? 1 : kin;
    wre = (k == 0) ? 1'b0 : wr;
    e = tl.pop_back();
    e.start = 1'b1; e.kind = 2'(kin); e.wr = wr;
    tl.push_back(e);
`ifdef DB_SEQ_WAIT_TIMEOUT_EN
    if (nwe >= TO) begin nwe = TO; to_hit = 1'b1; end
`endif
    s = (k == 2) ? 2 : 1;
    ph.push_back(P_T1);
    ph.push_back(P_T2);
    if (k == 2) ph.push_back(P_TWA);
    for (int i = 0; i < nwe; i++) ph.push_back(P_TW);
    ph.push_back(P_T3);
    if (k == 0) ph.push_back(P_T4);
    for (int i = 0; i < ph.size(); i++) begin
      e.start = (i == ph.size() - 1) ? 1'b0 : (hold ? 1'b1 : 1'($urandom));
      e.kind  = 2'($urandom);
      e.wr    = 1'($urandom);
      if (stuck)                   e.wait_n = 1'b0;
      else if (k == 2 && i == 1)   e.wait_n = 1'b0;
      else if (i >= s && i < s + nwe) e.wait_n = 1'b0;
      else if (i == s + nwe)       e.wait_n = 1'b1;
      else                         e.wait_n = 1'($urandom);
      e.exp = model(ph[i], k, wre, to_hit && ph[i] == P_T3);
      tl.push_back(e);
    end
  endtask

  task automatic play(string tag);
    n_m1 = 0; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_re = 0;
    n_we = 0; n_poe = 0; n_coe = 0; n_busy = 0; n_done = 0; n_to = 0;
    for (int i = 0; i < tl.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), obs, tl[i].exp);
      n_m1 += int'(!m1_n); n_mreq += int'(!mreq_n); n_iorq += int'(!iorq_n);
      n_rd += int'(!rd_n); n_wr += int'(!wr_n); n_re += int'(bus_db_pin_re);
      n_we += int'(ctl_bus_db_we); n_poe += int'(bus_db_pin_oe); n_coe += int'(ctl_bus_db_oe);
      n_busy += int'(busy); n_done += int'(done); n_to += int'(timeout);
      start = tl[i].start; cyc_kind = tl[i].kind; cyc_wr = tl[i].wr; wait_n = tl[i].wait_n;
    end
    start = 1'b0;
    tl.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cyc_kind = 2'b00; cyc_wr = 1'b0; wait_n = 1'b1;
    #3;
    check("reset_state", obs, 12'b0000_0001_1111);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fetch, no waits: T1 T2 T3 T4 (cyc_wr=1 must be ignored).
    add_idle(1); add_txn(0, 1'b1, 0, 1'b0, 1'b0); add_idle(1);
    play("fetch");
    check("fetch_m1_cnt", 12'(n_m1), 12'd3);
    check("fetch_re_cnt", 12'(n_re), 12'd1);
    check("fetch_coe_cnt", 12'(n_coe), 12'd2);
    check("fetch_len", 12'(n_busy), 12'd4);

    // Memory write with two wait samples: T1 T2 TW TW T3.
    add_idle(1); add_txn(1, 1'b1, 2, 1'b0, 1'b0); add_idle(1);
    play("memwr");
    check("memwr_we_cnt", 12'(n_we), 12'd1);
    check("memwr_poe_cnt", 12'(n_poe), 12'd4);
    check("memwr_wr_cnt", 12'(n_wr), 12'd3);
    check("memwr_len", 12'(n_busy), 12'd5);

    // I/O read with wait_n low in T2: auto wait wins, T1 T2 TWA T3.
    add_idle(1); add_txn(2, 1'b0, 0, 1'b0, 1'b0); add_idle(1);
    play("ioread");
    check("io_iorq_cnt", 12'(n_iorq), 12'd2);
    check("io_len", 12'(n_busy), 12'd4);

    // start held high: back-to-back memory reads, kind toggling mid-cycle.
    add_idle(1); add_txn(1, 1'b0, 0, 1'b1, 1'b0); add_txn(3, 1'b0, 1, 1'b1, 1'b0); add_idle(2);
    play("b2b");
    check("b2b_len", 12'(n_busy), 12'd7);
    check("b2b_done_cnt", 12'(n_done), 12'd2);

    // Reset asserted in T2 of a memory read.
    @(negedge clk); start = 1'b1; cyc_kind = 2'b01; cyc_wr = 1'b0; wait_n = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rst_pre_rd", 12'(rd_n), 12'd0);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 12'(busy), 12'd0);
    check("rst_strobes", {10'd0, rd_n, mreq_n}, 12'b11);
    check("rst_pin_re", 12'(bus_db_pin_re), 12'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_idle", obs, model(P_IDLE, 0, 1'b0, 1'b0));

`ifdef DB_SEQ_WAIT_TIMEOUT_EN
    // WAIT stuck low: three TW cycles then a forced T3 with timeout.
    add_idle(1); add_txn(1, 1'b0, 10, 1'b0, 1'b1); add_idle(2);
    play("tmo");
    check("tmo_len", 12'(n_busy), 12'd6);
    check("tmo_pulse_cnt", 12'(n_to), 12'd1);
`endif

    // Random traffic against the model.
    add_idle(1);
    for (int j = 0; j < 80; j++) begin
      add_txn($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), 1'b0);
      add_idle($urandom_range(0, 2));
    end
    add_idle(2);
    play("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
